// File: rtl/duty_ctrl_pkg.sv
// Shared mode encodings, mode sequencing and default timing constants for the
// duty-generator control stage.
package duty_ctrl_pkg;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1000000;
    localparam int unsigned DEFAULT_PRESCALE_DIV    = 50000;

    typedef enum logic [1:0] {
        SEL_MODE0 = 2'b00,
        SEL_MODE1 = 2'b01,
        SEL_MODE2 = 2'b10
    } sel_mode_e;

    // Any unexpected code (11) falls back to mode 0 on the next press.
    function automatic sel_mode_e next_mode(input sel_mode_e mode);
        case (mode)
            SEL_MODE0: next_mode = SEL_MODE1;
            SEL_MODE1: next_mode = SEL_MODE2;
            default:   next_mode = SEL_MODE0;
        endcase
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchronizer followed by a debounce filter; a new level is accepted
// only after it disagrees with the stable level for DEBOUNCE_CYCLES cycles.
module sync_debounce
    import duty_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic Reset,
    input  logic btn_raw,
    output logic btn_st
);

    localparam int unsigned   DW   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);

    logic          sync_q;
    logic          btn_s_q;
    logic          btn_st_q, btn_st_d;
    logic [DW-1:0] dcnt_q, dcnt_d;

    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            sync_q   <= 1'b0;
            btn_s_q  <= 1'b0;
            btn_st_q <= 1'b0;
            dcnt_q   <= '0;
        end else begin
            sync_q   <= btn_raw;
            btn_s_q  <= sync_q;
            btn_st_q <= btn_st_d;
            dcnt_q   <= dcnt_d;
        end
    end

    // Any agreement with the stable level restarts the count from zero.
    always_comb begin
        btn_st_d = btn_st_q;
        dcnt_d   = '0;
        if (btn_s_q != btn_st_q) begin
            if (dcnt_q == DMAX) begin
                btn_st_d = btn_s_q;
            end else begin
                dcnt_d = dcnt_q + DW'(1);
            end
        end
    end

    assign btn_st = btn_st_q;

endmodule

// File: rtl/duty_select_ctrl.sv
// Control stage for the two-bit down-counter duty generator: debounced mode
// select stepping on each press, plus a prescaled one-cycle count-enable tick.
module duty_select_ctrl
    import duty_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned PRESCALE_DIV    = DEFAULT_PRESCALE_DIV
) (
    input  logic       clock,
    input  logic       Reset,
    input  logic       btn_raw,
    input  logic       run_sw,
    output logic       En,
    output logic [1:0] select,
    output logic       btn_pulse
);

    localparam int unsigned   PW   = cnt_width(PRESCALE_DIV);
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE_DIV - 1);

    logic          btn_st;
    logic          btn_st_d_q;
    logic          press;
    logic          run_sync_q, run_s_q;
    logic          pulse_q;
    logic          en_q, en_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    sel_mode_e     sel_q, sel_d;

    sync_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clock  (clock),
        .Reset  (Reset),
        .btn_raw(btn_raw),
        .btn_st (btn_st)
    );

    assign press = btn_st & ~btn_st_d_q;

    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            btn_st_d_q <= 1'b0;
            run_sync_q <= 1'b0;
            run_s_q    <= 1'b0;
            pulse_q    <= 1'b0;
            en_q       <= 1'b0;
            pcnt_q     <= '0;
            sel_q      <= SEL_MODE0;
        end else begin
            btn_st_d_q <= btn_st;
            run_sync_q <= run_sw;
            run_s_q    <= run_sync_q;
            pulse_q    <= press;
            en_q       <= en_d;
            pcnt_q     <= pcnt_d;
            sel_q      <= sel_d;
        end
    end

    always_comb begin
        sel_d = sel_q;
        if (press) begin
            sel_d = next_mode(sel_q);
        end
    end

    // A press restarts the period so the new mode begins on a full tick interval.
    always_comb begin
        pcnt_d = pcnt_q + PW'(1);
        en_d   = 1'b0;
        if (!run_s_q || press) begin
            pcnt_d = '0;
        end else if (pcnt_q == PMAX) begin
            pcnt_d = '0;
            en_d   = 1'b1;
        end
    end

    always_comb begin
        En        = en_q;
        select    = sel_q;
        btn_pulse = pulse_q;
    end

endmodule

// File: tb/tb_duty_select_ctrl.sv
// Scoreboard bench for duty_select_ctrl: a behavioural model predicts press
// strobes and En ticks; a monitor matches them against the DUT outputs.
module tb_duty_select_ctrl;

    localparam int unsigned D = 4;
    localparam int unsigned P = 5;

    logic       clock = 1'b0;
    logic       Reset;
    logic       btn_raw;
    logic       run_sw;
    logic       En;
    logic [1:0] select;
    logic       btn_pulse;

    duty_select_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .PRESCALE_DIV   (P)
    ) dut (
        .clock    (clock),
        .Reset    (Reset),
        .btn_raw  (btn_raw),
        .run_sw   (run_sw),
        .En       (En),
        .select   (select),
        .btn_pulse(btn_pulse)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         at;
        logic [1:0] sel;
    } press_ev_t;

    press_ev_t press_q[$];
    int        tick_q[$];
    int        checks = 0;
    int        errors = 0;
    int        cyc = 0;

    // Model state: btn_s history, stable level, synchronized run level.
    bit bs_hist[$];
    bit raw_prev, st_cur, st_old, run_prev, runs_cur;
    int start_cyc, presses;

    function automatic logic [1:0] mode_of(input int p);
        int m = p % 3;
        return m[1:0];
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        bs_hist.delete();
        raw_prev  = 1'b0;
        st_cur    = 1'b0;
        st_old    = 1'b0;
        run_prev  = 1'b0;
        runs_cur  = 1'b0;
        start_cyc = cyc;
        presses   = 0;
    endtask

    // Edge cyc: the level is accepted once the last D synchronized samples all
    // disagree with it; a press is the cycle after acceptance of a high level;
    // ticks fall every P edges after the last restart (run low or a press).
    task automatic model_step(input bit b, input bit r);
        bit is_press, all_diff, tick;
        is_press = st_cur && !st_old;
        all_diff = (bs_hist.size() >= int'(D));
        for (int i = 0; i < int'(D) && all_diff; i++) begin
            if (bs_hist[bs_hist.size() - 1 - i] == st_cur) all_diff = 1'b0;
        end
        tick = 1'b0;
        if (!runs_cur || is_press) start_cyc = cyc;
        else if (((cyc - start_cyc) % int'(P)) == 0) tick = 1'b1;
        if (is_press) begin
            presses++;
            press_q.push_back('{at: cyc, sel: mode_of(presses)});
        end
        if (tick) tick_q.push_back(cyc);
        st_old = st_cur;
        if (all_diff) st_cur = !st_cur;
        bs_hist.push_back(raw_prev);
        if (bs_hist.size() > 16) void'(bs_hist.pop_front());
        raw_prev = b;
        runs_cur = run_prev;
        run_prev = r;
    endtask

    task automatic stepr(input bit rst, input bit b, input bit r);
        @(negedge clock);
        Reset   = rst;
        btn_raw = b;
        run_sw  = r;
        @(posedge clock);
        cyc++;
        if (Reset) model_reset();
        else model_step(b, r);
    endtask

    task automatic step(input bit b, input bit r);
        stepr(1'b0, b, r);
    endtask

    task automatic check_reset_outputs();
        check("rst_En", En, 0);
        check("rst_select", select, 0);
        check("rst_btn_pulse", btn_pulse, 0);
    endtask

    task automatic clean_press(input bit r);
        repeat (8) step(1'b1, r);
        repeat (8) step(1'b0, r);
    endtask

    // Monitor: every strobe/tick the DUT presents must match the head of its queue.
    initial begin
        press_ev_t ev;
        forever begin
            @(negedge clock);
            if (!Reset) begin
                while (press_q.size() > 0 && press_q[0].at < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL missing_pulse: got none expected pulse at cycle %0d",
                             press_q[0].at);
                    void'(press_q.pop_front());
                end
                while (tick_q.size() > 0 && tick_q[0] < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL missing_tick: got none expected En at cycle %0d", tick_q[0]);
                    void'(tick_q.pop_front());
                end
                if (btn_pulse) begin
                    if (press_q.size() > 0 && press_q[0].at == cyc) begin
                        ev = press_q.pop_front();
                        check("pulse_select", select, ev.sel);
                    end else begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_pulse: got pulse at cycle %0d expected none",
                                 cyc);
                    end
                end
                if (En) begin
                    if (tick_q.size() > 0 && tick_q[0] == cyc) begin
                        void'(tick_q.pop_front());
                        checks++;
                    end else begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_tick: got En at cycle %0d expected none", cyc);
                    end
                end
            end
        end
    end

    initial begin
        bit lvl, rn;
        Reset   = 1'b1;
        btn_raw = 1'b0;
        run_sw  = 1'b0;
        model_reset();
        repeat (3) stepr(1'b1, 1'b0, 1'b0);
        #1;
        check_reset_outputs();

        // Clean presses walk 00 -> 01 -> 10 -> 00.
        for (int p = 0; p < 3; p++) clean_press(1'b0);
        check("select_after_3", select, mode_of(presses));

        // Bounce shorter than the debounce window is rejected.
        repeat (3) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        repeat (3) step(1'b1, 1'b0);
        repeat (12) step(1'b0, 1'b0);
        check("select_bounce", select, mode_of(presses));
        check("bounce_presses", presses, 3);
        repeat (6) step(1'b1, 1'b0);
        repeat (12) step(1'b0, 1'b0);
        check("select_held", select, mode_of(presses));

        // Steady ticking then stop.
        repeat (30) step(1'b0, 1'b1);
        repeat (10) step(1'b0, 1'b0);

        // Press landing exactly on a tick boundary.
        repeat (8) step(1'b0, 1'b1);
        for (int g = 0; g < 10 && ((cyc + 7 - start_cyc) % int'(P)) != 0; g++) step(1'b0, 1'b1);
        repeat (10) step(1'b1, 1'b1);
        repeat (20) step(1'b0, 1'b1);
        check("select_collision", select, mode_of(presses));

        // Long hold, then a bouncy release: one step only.
        repeat (100) step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        repeat (12) step(1'b0, 1'b1);
        check("select_long_hold", select, mode_of(presses));

        // Randomized buttons and run switch.
        lvl = 1'b0;
        rn  = 1'b1;
        repeat (3000) begin
            if ($urandom_range(3) == 0) lvl = !lvl;
            if ($urandom_range(39) == 0) rn = !rn;
            step(lvl, rn);
        end
        repeat (12) step(1'b0, 1'b1);

        // Asynchronous reset mid-operation with a debounce in progress.
        if (mode_of(presses) == 2'b00) clean_press(1'b1);
        check("select_pre_reset", select, mode_of(presses));
        repeat (2) step(1'b1, 1'b1);
        #2;
        Reset = 1'b1;
        press_q.delete();
        tick_q.delete();
        #1;
        check_reset_outputs();
        repeat (3) begin
            stepr(1'b1, 1'b1, 1'b1);
            #1;
            check_reset_outputs();
        end
        repeat (10) step(1'b1, 1'b1);
        repeat (10) step(1'b0, 1'b1);
        check("select_post_reset", select, mode_of(presses));

        repeat (300) begin
            if ($urandom_range(3) == 0) lvl = !lvl;
            if ($urandom_range(39) == 0) rn = !rn;
            step(lvl, rn);
        end
        repeat (12) step(1'b0, 1'b0);

        check("pending_pulses", press_q.size(), 0);
        check("pending_ticks", tick_q.size(), 0);
        check("select_final", select, mode_of(presses));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/duty_select_ctrl.md
Name: duty_select_ctrl

Overview:
- Upstream control stage for the two-bit down-counter duty generator.
- Turns a raw pushbutton into a debounced mode-select code that steps 00 -> 01 -> 10 -> 00 on each press.
- Turns a raw run switch into a periodic one-cycle count-enable tick from a programmable prescaler.
- Drives the counter's En and select inputs directly; all outputs are registered.

Parameters:
- DEBOUNCE_CYCLES, default 1000000: consecutive cycles a synchronized button level must persist before it is accepted; must be >= 2.
- PRESCALE_DIV, default 50000: clock cycles per En tick; must be >= 2.
- Counter widths are $clog2 of each parameter, minimum 1.

Ports:
- clock  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high; clears all state.
- btn_raw  input  1  raw pushbutton, asynchronous to clock, may bounce.
- run_sw  input  1  raw run switch, asynchronous; 1 = ticks enabled.
- En  output  1  one-cycle count-enable tick to the down-counter.
- select  output  2  duty mode code to the down-counter; only 00/01/10 are legal.
- btn_pulse  output  1  one-cycle strobe marking an accepted press (debug/status).

Behaviour:
- Reset: asynchronous assert, synchronous release through the normal flops. While Reset=1:
  - En=0, select=00, btn_pulse=0.
  - Synchronizer flops, debounce counter, stable level, prescaler counter all 0.
- Reset mid-operation aborts any debounce or prescale in progress, with no pulse emitted.
- Synchronizers: two flops each on btn_raw and run_sw; outputs btn_s and run_s.
- Debounce (btn_s only):
  - Holds stable level btn_st and counter dcnt.
  - If btn_s == btn_st: dcnt <= 0.
  - Else if dcnt == DEBOUNCE_CYCLES-1: btn_st <= btn_s, dcnt <= 0.
  - Else: dcnt <= dcnt+1.
  - Any disagreement shorter than DEBOUNCE_CYCLES cycles is rejected, and dcnt restarts from 0 on every bounce.
- Press detect: btn_pulse <= btn_st & ~btn_st_d, where btn_st_d is btn_st delayed one cycle. Only rising edges count; release is ignored.
- Latency: btn_raw sampled high first at edge k and held. Then btn_st rises at edge k+1+DEBOUNCE_CYCLES; btn_pulse and the select update both occur at edge k+2+DEBOUNCE_CYCLES.
- Select FSM, states SEL0=00, SEL1=01, SEL2=10:
  - On btn_pulse condition: 00->01, 01->10, 10->00.
  - Otherwise hold.
  - 11 is unreachable; if it ever appears, the next press goes to 00.
- Prescaler, counter pcnt:
  - run_s == 0: pcnt <= 0, En <= 0.
  - Press condition in the same cycle (priority over ticking): pcnt <= 0, En <= 0, so the new mode starts on a full period.
  - pcnt == PRESCALE_DIV-1: pcnt <= 0, En <= 1.
  - Otherwise: pcnt <= pcnt+1, En <= 0.
- Steady run: first En goes high PRESCALE_DIV cycles after run_s rises. Spacing is then exactly PRESCALE_DIV cycles, i.e. duty 1/PRESCALE_DIV.
- Simultaneous press and tick boundary: the tick is suppressed, select advances, and the prescaler restarts.
- run_s falling while En=1: En drops the next cycle, with no partial tick later.

Decomposition:
- Package duty_ctrl_pkg holds:
  - select encodings SEL_MODE0=2'b00, SEL_MODE1=2'b01, SEL_MODE2=2'b10;
  - the next-mode function;
  - default parameter constants.
- One sub-module: sync_debounce. It covers the 2-flop synchronizer, the debounce counter and the stable-level register, is parameterized by DEBOUNCE_CYCLES, and outputs the stable level.
- The press edge detect, select FSM and prescaler live in duty_select_ctrl.

Test Plan (DEBOUNCE_CYCLES=4, PRESCALE_DIV=5):
- Reset: assert Reset mid-cycle with run_sw=1 -> En, select, btn_pulse go to 0/00/0 immediately without a clock edge; stay there until release.
- Clean press: btn_raw 0->1 sampled at edge k and held -> btn_pulse=1 for exactly one cycle after edge k+6. select goes 00->01 at edge k+6, and further presses give 10 then 00.
- Bounce: btn_raw high 3 cycles, low 1, high 3, low -> no btn_pulse, select stays 00. Holding high for 4+ cycles -> exactly one pulse.
- Ticking: run_sw=1 held -> En high one cycle every 5 cycles, first tick 5 cycles after run_s rises. run_sw=0 -> En stays 0 and pcnt resets.
- Collision: press accepted on the cycle pcnt==4 -> En stays 0 that cycle, select advances, next En exactly 5 cycles later.
- Long hold: btn_raw held high for 100 cycles, then released with bounce -> exactly one select step total.
